// File: rtl/ddr4_app_arbiter.sv
// Two-requester round-robin arbiter onto the DDR4 controller native app port.
// Single-beat commands; a tag FIFO routes in-order read returns to their issuer.
module ddr4_app_arbiter #(
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 512,
  parameter int MASK_WIDTH = 64,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                         c0_ddr4_ui_clk,
  input  logic                         c0_ddr4_ui_clk_sync_rst,
  input  logic                         rq0_valid,
  output logic                         rq0_ready,
  input  logic                         rq0_we,
  input  logic [ADDR_WIDTH-1:0]        rq0_addr,
  input  logic [DATA_WIDTH-1:0]        rq0_wdata,
  input  logic [MASK_WIDTH-1:0]        rq0_wmask,
  input  logic                         rq1_valid,
  output logic                         rq1_ready,
  input  logic                         rq1_we,
  input  logic [ADDR_WIDTH-1:0]        rq1_addr,
  input  logic [DATA_WIDTH-1:0]        rq1_wdata,
  input  logic [MASK_WIDTH-1:0]        rq1_wmask,
  output logic                         rsp0_valid,
  output logic [DATA_WIDTH-1:0]        rsp0_data,
  output logic                         rsp1_valid,
  output logic [DATA_WIDTH-1:0]        rsp1_data,
  output logic                         app_en,
  output logic [2:0]                   app_cmd,
  output logic [ADDR_WIDTH-1:0]        app_addr,
  input  logic                         app_rdy,
  output logic                         app_wdf_wren,
  output logic                         app_wdf_end,
  output logic [DATA_WIDTH-1:0]        app_wdf_data,
  output logic [MASK_WIDTH-1:0]        app_wdf_mask,
  input  logic                         app_wdf_rdy,
  input  logic                         app_rd_data_valid,
  input  logic [DATA_WIDTH-1:0]        app_rd_data,
  output logic [$clog2(TAG_DEPTH):0]   rd_outstanding,
  output logic                         err_unexpected_rd
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  logic clk;
  logic rst;
  assign clk = c0_ddr4_ui_clk;
  assign rst = c0_ddr4_ui_clk_sync_rst;

  // Handshake: a request transfers in the cycle rqN_valid && rqN_ready; the
  // requester holds valid and payload until then. app_en is only raised with
  // app_rdy high, so every presented command is taken in that same cycle.

  logic                  last_winner;
  logic                  lock;
  logic                  lock_id;
  logic [TAG_DEPTH-1:0]  tag_mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      rd_count;
  logic                  err_q;

  logic                  sel_id;
  logic                  sel_valid;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [MASK_WIDTH-1:0] sel_wmask;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  issue;
  logic                  blocked;
  logic                  push;
  logic                  pop;
  logic                  ret_tag;

  always_comb begin
    sel_id    = 1'b0;
    sel_valid = 1'b0;
    if (lock) begin
      sel_id    = lock_id;
      sel_valid = lock_id ? rq1_valid : rq0_valid;
    end else if (rq0_valid && rq1_valid) begin
      sel_id    = ~last_winner;
      sel_valid = 1'b1;
    end else begin
      sel_id    = rq1_valid;
      sel_valid = rq0_valid | rq1_valid;
    end
  end

  always_comb begin
    sel_we    = sel_id ? rq1_we    : rq0_we;
    sel_addr  = sel_id ? rq1_addr  : rq0_addr;
    sel_wdata = sel_id ? rq1_wdata : rq0_wdata;
    sel_wmask = sel_id ? rq1_wmask : rq0_wmask;
  end

  // Full is judged on registered occupancy; a same-cycle return does not help.
  assign fifo_full  = (rd_count == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (rd_count == '0);
  assign issue      = sel_valid && !rst && app_rdy && (sel_we ? app_wdf_rdy : !fifo_full);
  assign blocked    = sel_valid && !rst && !issue;
  assign push       = issue && !sel_we;
  assign pop        = app_rd_data_valid && !fifo_empty && !rst;
  assign ret_tag    = tag_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner <= 1'b1;
      lock        <= 1'b0;
      lock_id     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_count    <= '0;
      err_q       <= 1'b0;
    end else begin
      if (issue) begin
        last_winner <= sel_id;
        lock        <= 1'b0;
      end else if (blocked) begin
        lock    <= 1'b1;
        lock_id <= sel_id;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   rd_count <= rd_count + CNT_W'(1);
        2'b01:   rd_count <= rd_count - CNT_W'(1);
        default: rd_count <= rd_count;
      endcase
      if (app_rd_data_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= sel_id;
  end

  assign rq0_ready    = issue && !sel_id;
  assign rq1_ready    = issue && sel_id;
  assign app_en       = issue;
  assign app_cmd      = (issue && sel_we) ? CMD_WR : CMD_RD;
  assign app_addr     = issue ? sel_addr : '0;
  assign app_wdf_wren = issue && sel_we;
  assign app_wdf_end  = issue && sel_we;
  assign app_wdf_data = app_wdf_wren ? sel_wdata : '0;
  assign app_wdf_mask = app_wdf_wren ? sel_wmask : '0;

  assign rsp0_valid = pop && !ret_tag;
  assign rsp1_valid = pop && ret_tag;
  assign rsp0_data  = rsp0_valid ? app_rd_data : '0;
  assign rsp1_data  = rsp1_valid ? app_rd_data : '0;

  assign rd_outstanding    = rd_count;
  assign err_unexpected_rd = err_q;

endmodule

// File: tb/tb_ddr4_app_arbiter.sv
// Directed bench for ddr4_app_arbiter: arbitration order, write lock,
// tag FIFO routing, full stall, same-cycle issue/return and error flag.
module tb_ddr4_app_arbiter;

  localparam int AW = 34;
  localparam int DW = 512;
  localparam int MW = 64;
  localparam int TD = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rq0_valid, rq0_ready, rq0_we;
  logic [AW-1:0] rq0_addr;
  logic [DW-1:0] rq0_wdata;
  logic [MW-1:0] rq0_wmask;
  logic          rq1_valid, rq1_ready, rq1_we;
  logic [AW-1:0] rq1_addr;
  logic [DW-1:0] rq1_wdata;
  logic [MW-1:0] rq1_wmask;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_rdy;
  logic          app_wdf_wren, app_wdf_end;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic          app_wdf_rdy;
  logic          app_rd_data_valid;
  logic [DW-1:0] app_rd_data;
  logic [4:0]    rd_outstanding;
  logic          err_unexpected_rd;

  int n_checks = 0;
  int n_fail   = 0;

  ddr4_app_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .TAG_DEPTH(TD)) dut (
    .c0_ddr4_ui_clk(clk), .c0_ddr4_ui_clk_sync_rst(rst),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_we(rq0_we), .rq0_addr(rq0_addr),
    .rq0_wdata(rq0_wdata), .rq0_wmask(rq0_wmask),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_we(rq1_we), .rq1_addr(rq1_addr),
    .rq1_wdata(rq1_wdata), .rq1_wmask(rq1_wmask),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
    .rd_outstanding(rd_outstanding), .err_unexpected_rd(err_unexpected_rd)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    rq0_valid = 1'b0; rq0_we = 1'b0; rq0_addr = '0; rq0_wdata = '0; rq0_wmask = '0;
    rq1_valid = 1'b0; rq1_we = 1'b0; rq1_addr = '0; rq1_wdata = '0; rq1_wmask = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // checkers
  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] pat_a5;
  logic [DW-1:0] wpat;
  logic [DW-1:0] d;

  initial begin
    pat_a5 = {64{8'hA5}};
    wpat   = {16{32'h1234_5678}};

    // reset state
    do_reset();
    settle();
    chk_b("rst_app_en", app_en, 1'b0);
    chk_w("rst_app_cmd", DW'(app_cmd), DW'(3'b001));
    chk_w("rst_outstanding", DW'(rd_outstanding), DW'(0));
    chk_b("rst_err", err_unexpected_rd, 1'b0);
    chk_b("rst_rq0_ready", rq0_ready, 1'b0);
    chk_b("rst_wren", app_wdf_wren, 1'b0);

    // single read from rq0, return 5 cycles later
    rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = AW'(34'h100);
    settle();
    chk_b("rd1_rq0_ready", rq0_ready, 1'b1);
    chk_b("rd1_app_en", app_en, 1'b1);
    chk_w("rd1_app_cmd", DW'(app_cmd), DW'(3'b001));
    chk_w("rd1_app_addr", DW'(app_addr), DW'(34'h100));
    chk_w("rd1_cnt0", DW'(rd_outstanding), DW'(0));
    cyc();
    rq0_valid = 1'b0;
    settle();
    chk_w("rd1_cnt1", DW'(rd_outstanding), DW'(1));
    chk_b("rd1_no_ready", rq0_ready, 1'b0);
    repeat (4) cyc();
    app_rd_data_valid = 1'b1; app_rd_data = pat_a5;
    settle();
    chk_b("rd1_rsp0_valid", rsp0_valid, 1'b1);
    chk_b("rd1_rsp1_valid", rsp1_valid, 1'b0);
    chk_w("rd1_rsp0_data", rsp0_data, pat_a5);
    cyc();
    app_rd_data_valid = 1'b0;
    settle();
    chk_b("rd1_rsp0_drop", rsp0_valid, 1'b0);
    chk_w("rd1_cnt_back", DW'(rd_outstanding), DW'(0));

    // both requesters reading continuously: grants alternate 0,1,0,1
    do_reset();
    rq0_valid = 1'b1; rq0_addr = AW'(34'h200);
    rq1_valid = 1'b1; rq1_addr = AW'(34'h300);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_b("alt_rq0_ready", rq0_ready, (i % 2) == 0);
      chk_b("alt_rq1_ready", rq1_ready, (i % 2) == 1);
      chk_w("alt_addr", DW'(app_addr), (i % 2) == 0 ? DW'(34'h200) : DW'(34'h300));
      cyc();
    end
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    settle();
    chk_w("alt_cnt4", DW'(rd_outstanding), DW'(4));
    for (int i = 0; i < 4; i++) begin
      d = {16{32'hC0DE_0000 + 32'(i)}};
      app_rd_data_valid = 1'b1; app_rd_data = d;
      settle();
      chk_b("alt_rsp0_valid", rsp0_valid, (i % 2) == 0);
      chk_b("alt_rsp1_valid", rsp1_valid, (i % 2) == 1);
      chk_w("alt_rsp_data", (i % 2) == 0 ? rsp0_data : rsp1_data, d);
      cyc();
    end
    app_rd_data_valid = 1'b0;
    settle();
    chk_w("alt_cnt0", DW'(rd_outstanding), DW'(0));

    // rq1 write blocked by app_wdf_rdy for 3 cycles; lock keeps rq1 ahead of rq0
    app_wdf_rdy = 1'b0;
    rq1_valid = 1'b1; rq1_we = 1'b1; rq1_addr = AW'(34'h440);
    rq1_wdata = wpat; rq1_wmask = 64'h0000_0000_0000_00FF;
    settle();
    chk_b("lock_a_rq1_ready", rq1_ready, 1'b0);
    chk_b("lock_a_app_en", app_en, 1'b0);
    chk_b("lock_a_wren", app_wdf_wren, 1'b0);
    cyc();
    rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = AW'(34'h500);
    for (int i = 0; i < 2; i++) begin
      settle();
      chk_b("lock_b_rq0_ready", rq0_ready, 1'b0);
      chk_b("lock_b_rq1_ready", rq1_ready, 1'b0);
      chk_b("lock_b_app_en", app_en, 1'b0);
      cyc();
    end
    app_wdf_rdy = 1'b1;
    settle();
    chk_b("lock_d_rq1_ready", rq1_ready, 1'b1);
    chk_b("lock_d_rq0_ready", rq0_ready, 1'b0);
    chk_b("lock_d_app_en", app_en, 1'b1);
    chk_b("lock_d_wren", app_wdf_wren, 1'b1);
    chk_b("lock_d_end", app_wdf_end, 1'b1);
    chk_w("lock_d_cmd", DW'(app_cmd), DW'(3'b000));
    chk_w("lock_d_addr", DW'(app_addr), DW'(34'h440));
    chk_w("lock_d_wdata", app_wdf_data, wpat);
    chk_w("lock_d_wmask", DW'(app_wdf_mask), DW'(64'hFF));
    cyc();
    rq1_valid = 1'b0; rq1_we = 1'b0;
    settle();
    chk_b("lock_e_rq0_ready", rq0_ready, 1'b1);
    chk_w("lock_e_cmd", DW'(app_cmd), DW'(3'b001));
    chk_w("lock_e_addr", DW'(app_addr), DW'(34'h500));
    chk_b("lock_e_wren", app_wdf_wren, 1'b0);
    cyc();
    rq0_valid = 1'b0;
    settle();
    chk_w("lock_cnt1", DW'(rd_outstanding), DW'(1));
    app_rd_data_valid = 1'b1; app_rd_data = pat_a5;
    settle();
    chk_b("lock_rsp0_valid", rsp0_valid, 1'b1);
    cyc();
    app_rd_data_valid = 1'b0;

    // 16 reads fill the tag FIFO; 17th stalls until a return has been absorbed
    do_reset();
    rq0_valid = 1'b1; rq0_addr = AW'(34'h600);
    for (int i = 0; i < TD; i++) begin
      settle();
      chk_b("fill_ready", rq0_ready, 1'b1);
      cyc();
    end
    settle();
    chk_b("full_ready", rq0_ready, 1'b0);
    chk_b("full_app_en", app_en, 1'b0);
    chk_w("full_cnt16", DW'(rd_outstanding), DW'(16));
    cyc();
    app_rd_data_valid = 1'b1; app_rd_data = pat_a5;
    settle();
    chk_b("full_ret_ready", rq0_ready, 1'b0);
    chk_b("full_ret_rsp0", rsp0_valid, 1'b1);
    cyc();
    app_rd_data_valid = 1'b0;
    settle();
    chk_w("full_cnt15", DW'(rd_outstanding), DW'(15));
    chk_b("full_next_ready", rq0_ready, 1'b1);
    cyc();
    rq0_valid = 1'b0;
    settle();
    chk_w("full_cnt16b", DW'(rd_outstanding), DW'(16));

    // issue and return in the same cycle leave the count unchanged
    app_rd_data_valid = 1'b1;
    cyc();
    settle();
    chk_w("same_pre_cnt", DW'(rd_outstanding), DW'(15));
    rq0_valid = 1'b1;
    settle();
    chk_b("same_ready", rq0_ready, 1'b1);
    chk_b("same_rsp0", rsp0_valid, 1'b1);
    cyc();
    rq0_valid = 1'b0; app_rd_data_valid = 1'b0;
    settle();
    chk_w("same_cnt", DW'(rd_outstanding), DW'(15));
    app_rd_data_valid = 1'b1;
    repeat (15) cyc();
    app_rd_data_valid = 1'b0;
    settle();
    chk_w("drain_cnt", DW'(rd_outstanding), DW'(0));
    chk_b("drain_err", err_unexpected_rd, 1'b0);

    // return with the FIFO empty: dropped, sticky error until reset
    app_rd_data_valid = 1'b1; app_rd_data = pat_a5;
    settle();
    chk_b("unexp_rsp0", rsp0_valid, 1'b0);
    chk_b("unexp_rsp1", rsp1_valid, 1'b0);
    cyc();
    app_rd_data_valid = 1'b0;
    settle();
    chk_b("unexp_err_set", err_unexpected_rd, 1'b1);
    repeat (3) cyc();
    chk_b("unexp_err_sticky", err_unexpected_rd, 1'b1);
    chk_w("unexp_cnt", DW'(rd_outstanding), DW'(0));
    do_reset();
    settle();
    chk_b("unexp_err_clr", err_unexpected_rd, 1'b0);

    // reset mid-operation discards outstanding tags
    rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = AW'(34'h700);
    settle();
    chk_b("mid_rq1_ready", rq1_ready, 1'b1);
    cyc();
    rq1_valid = 1'b0;
    settle();
    chk_w("mid_cnt1", DW'(rd_outstanding), DW'(1));
    do_reset();
    settle();
    chk_w("mid_cnt0", DW'(rd_outstanding), DW'(0));
    app_rd_data_valid = 1'b1;
    settle();
    chk_b("mid_rsp1", rsp1_valid, 1'b0);
    cyc();
    app_rd_data_valid = 1'b0;
    settle();
    chk_b("mid_err", err_unexpected_rd, 1'b1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
